mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width, matching the 1024-word unified memory.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MEM_LAT, default 2, legal 1..4, cycles from mem_en to valid mem_rdata.
REQ-004 Parameter STARVE_MAX, default 3, legal 1..15, max consecutive data grants while the instruction port waits.
REQ-005 clk  input  1  sole clock, all state updates on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_req  input  1  instruction-fetch read request, held until i_gnt.
REQ-008 i_addr  input  AW  fetch word address.
REQ-009 i_flush  input  1  taken branch; discard any outstanding fetch response.
REQ-010 i_gnt  output  1  fetch request accepted (one-cycle pulse).
REQ-011 i_rvalid  output  1  fetch data valid (one-cycle pulse).
REQ-012 i_rdata  output  DW  fetch data.
REQ-013 d_req  input  1  data-port request (LW/SW), held until d_gnt.
REQ-014 d_we  input  1  1 = store, 0 = load.
REQ-015 d_addr  input  AW  data word address.
REQ-016 d_wdata  input  DW  store data.
REQ-017 d_gnt  output  1  data request accepted (one-cycle pulse).
REQ-018 d_rvalid  output  1  load data valid, or store complete (one-cycle pulse).
REQ-019 d_rdata  output  DW  load data (0 for stores).
REQ-020 mem_en  output  1  memory access strobe.
REQ-021 mem_we  output  1  memory write enable.
REQ-022 mem_addr  output  AW  memory address.
REQ-023 mem_wdata  output  DW  memory write data.
REQ-024 mem_rdata  input  DW  memory read data.
REQ-025 busy  output  1  high whenever state is not IDLE.

Function
REQ-026 FSM states: IDLE, ACCESS, RESP; at most one transaction outstanding.
REQ-027 IDLE with any request: grant pulses combinationally in that cycle (cycle G); request fields and owner latch at end of G; next state is ACCESS with cnt=0.
REQ-028 Arbitration: data port has priority over fetch, except when both request and starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-029 starve_cnt: +1 on each d_gnt while i_req=1; cleared on i_gnt, or on a d_gnt with i_req=0; saturates at STARVE_MAX.
REQ-030 mem_en is registered and high only in cycle G+1; mem_we, mem_addr and mem_wdata are valid in G+1; mem_we is 0 for fetches; all memory outputs are 0 when mem_en=0.
REQ-031 ACCESS lasts MEM_LAT+1 cycles (cnt 0..MEM_LAT); mem_rdata is captured at end of the last ACCESS cycle (G+1+MEM_LAT); next state is RESP.
REQ-032 RESP lasts exactly 1 cycle (G+2+MEM_LAT); the owner's rvalid=1 with captured data; next state is IDLE; no grant is issued in RESP.
REQ-033 i_flush=1 in any cycle from G through RESP of a fetch transaction suppresses that i_rvalid; FSM timing is unchanged.
REQ-034 i_flush has no effect on data transactions; stores always complete.
REQ-035 i_rdata and d_rdata hold their last value between pulses; d_rdata is 0 after a store.
REQ-036 Requests deasserted before grant are ignored; no grant is issued without req.

Reset
REQ-037 rst=1 at a posedge: state=IDLE, starve_cnt=0, cnt=0, any transaction abandoned (no rvalid issued).
REQ-038 Reset values: all outputs 0, including busy, grants, rvalids, rdata, mem_*.
REQ-039 Grants are combinationally forced to 0 while rst=1.

Verification
REQ-040 Single fetch, MEM_LAT=2: i_req, i_addr=5, mem[5]=0xDEADBEEF -> i_gnt cycle 0, mem_en/mem_addr=5 cycle 1, i_rvalid with 0xDEADBEEF cycle 4, busy cycles 1-4.
REQ-041 Store then load: d_we=1, addr=7, wdata=0x12345678 -> mem_we=1 in G+1, d_rvalid at G+4, d_rdata=0; load addr 7 -> d_rdata=0x12345678.
REQ-042 Contention, STARVE_MAX=3: i_req and d_req held continuously -> grant order D,D,D,I,D,D,D,I.
REQ-043 Flush: fetch granted, i_flush pulsed in cycle G+2 -> no i_rvalid, FSM returns to IDLE at G+5, next grant possible at G+5.
REQ-044 Reset mid-ACCESS: rst at G+2 of a load -> no d_rvalid, all outputs 0 next cycle, new request granted in first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported fixed-latency memory.
// One transaction in flight: IDLE grants, ACCESS waits MEM_LAT, RESP returns data.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          own_i_q, own_i_d;
  logic          we_q, we_d;
  logic          flushed_q, flushed_d;
  logic [DW-1:0] cap_q, cap_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;

  // Arbitration: data first unless the fetch port has waited out STARVE_MAX data grants.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (d_req && !(i_req && starve_q == STARVE_LIM)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else begin
        d_gnt = 1'b0;
      end
    end else begin
      i_gnt = 1'b0;
    end
  end

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    own_i_d     = own_i_q;
    we_d        = we_q;
    flushed_d   = flushed_q;
    cap_d       = cap_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {AW{1'b0}};
    mem_wdata_d = {DW{1'b0}};
    i_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_gnt || d_gnt) begin
          state_d     = ACCESS;
          cnt_d       = 3'd0;
          own_i_d     = i_gnt;
          we_d        = d_gnt && d_we;
          flushed_d   = i_gnt && i_flush;
          mem_en_d    = 1'b1;
          mem_we_d    = d_gnt && d_we;
          mem_addr_d  = d_gnt ? d_addr : i_addr;
          mem_wdata_d = (d_gnt && d_we) ? d_wdata : {DW{1'b0}};
          if (d_gnt && i_req) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        flushed_d = flushed_q || i_flush;
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = 3'd0;
          if (own_i_q) begin
            cap_d      = mem_rdata;
            i_rvalid_d = !(flushed_q || i_flush);
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? {DW{1'b0}} : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d   = IDLE;
        // A flush landing in RESP kills the pulse, so the held value must not move.
        i_rdata_d = i_rvalid ? cap_q : i_rdata_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      own_i_q     <= 1'b0;
      we_q        <= 1'b0;
      flushed_q   <= 1'b0;
      cap_q       <= {DW{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= {DW{1'b0}};
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      own_i_q     <= own_i_d;
      we_q        <= we_d;
      flushed_q   <= flushed_d;
      cap_q       <= cap_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rvalid_q  <= i_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_rvalid  = i_rvalid_q && !i_flush;
  assign i_rdata   = i_rvalid ? cap_q : i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fixed-latency memory responder, a
// transaction-level reference model checked every cycle, and literal spot checks.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int SM = 3;
  localparam logic [63:0] EXP_ORD = "DDDIDDDI";

  logic          clk = 1'b0;
  logic          rst, mem_init;
  logic          i_req, i_flush, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int pc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pc++;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  // Memory responder: write on strobe, read data appears L cycles after mem_en.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] pipe [0:L-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem_en ? mem[mem_addr] : 32'h0;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[L-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, pc);
    end
  endtask

  // Reference model: one outstanding transaction described by its grant cycle.
  logic [DW-1:0] mmem [0:1023];
  bit            mv = 1'b0, tv = 1'b0, tfetch, twe, tflushed;
  int            tg = 0, starve = 0;
  logic [AW-1:0] taddr;
  logic [DW-1:0] twdata, tdata, li, ld;

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = pat(i);
  end

  always @(negedge clk) begin
    int rel;
    bit free, eig, edg, ebusy, emen, emwe, eirv, edrv;
    logic [AW-1:0] emaddr;
    rel   = pc - tg;
    free  = !tv || rel >= 3 + L;
    if (tv && tfetch && rel <= 2 + L && i_flush) tflushed = 1'b1;
    ebusy  = tv && rel >= 1 && rel <= 2 + L;
    emen   = tv && rel == 1;
    emwe   = emen && twe;
    emaddr = emen ? taddr : 10'd0;
    eirv   = tv && rel == 2 + L && tfetch && !tflushed;
    edrv   = tv && rel == 2 + L && !tfetch;
    if (eirv) li = tdata;
    if (edrv) ld = twe ? 32'h0 : tdata;
    eig = 1'b0;
    edg = 1'b0;
    if (!rst && free) begin
      if (d_req && !(i_req && starve == SM)) edg = 1'b1;
      else if (i_req) eig = 1'b1;
    end
    chk("i_gnt", 64'(i_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    if (mv) begin
      chk("busy", 64'(busy), 64'(ebusy));
      chk("mem_en", 64'(mem_en), 64'(emen));
      chk("mem_we", 64'(mem_we), 64'(emwe));
      chk("mem_addr", 64'(mem_addr), 64'(emaddr));
      if (!emen) chk("mem_wdata_idle", 64'(mem_wdata), 64'd0);
      if (emwe) chk("mem_wdata", 64'(mem_wdata), 64'(twdata));
      chk("i_rvalid", 64'(i_rvalid), 64'(eirv));
      chk("d_rvalid", 64'(d_rvalid), 64'(edrv));
      chk("i_rdata", 64'(i_rdata), 64'(li));
      chk("d_rdata", 64'(d_rdata), 64'(ld));
    end
    if (rst) begin
      mv = 1'b1; tv = 1'b0; starve = 0; li = 32'h0; ld = 32'h0;
    end else if (edg || eig) begin
      tv = 1'b1; tg = pc; tfetch = eig; twe = edg && d_we;
      taddr = edg ? d_addr : i_addr;
      twdata = d_wdata;
      tflushed = eig && i_flush;
      tdata = mmem[taddr];
      if (twe) mmem[taddr] = twdata;
      if (edg && i_req) starve = (starve == SM) ? SM : starve + 1;
      else starve = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (pc < c) step();
    @(negedge clk);
  endtask

  task automatic req_fetch(input logic [AW-1:0] a, output int g);
    step();
    i_req = 1'b1; i_addr = a; g = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_gnt) begin g = pc; break; end
      step();
    end
    step();
    i_req = 1'b0; i_addr = 10'd0;
    if (g < 0) begin checks++; errors++; $display("FAIL fetch_grant_timeout addr %0d", a); end
  endtask

  task automatic req_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int g);
    step();
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; g = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_gnt) begin g = pc; break; end
      step();
    end
    step();
    d_req = 1'b0; d_we = 1'b0; d_addr = 10'd0; d_wdata = 32'h0;
    if (g < 0) begin checks++; errors++; $display("FAIL data_grant_timeout addr %0d", a); end
  endtask

  initial begin
    int g, g2, n;
    logic [63:0] ord;
    rst = 1'b1; mem_init = 1'b1; i_req = 1'b1; d_req = 1'b1; i_flush = 1'b0;
    i_addr = 10'd0; d_addr = 10'd0; d_we = 1'b0; d_wdata = 32'h0;
    step(); step();
    mem_init = 1'b0; i_req = 1'b0; d_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single fetch; a data request dropped while busy must never be granted.
    req_fetch(10'd5, g);
    d_req = 1'b1; d_addr = 10'd1;
    @(negedge clk);
    chk("fetch_mem_en_g1", 64'(mem_en), 64'd1);
    chk("fetch_mem_addr_g1", 64'(mem_addr), 64'd5);
    step();
    d_req = 1'b0; d_addr = 10'd0;
    wait_to(g + 4);
    chk("fetch_rvalid_g4", 64'(i_rvalid), 64'd1);
    chk("fetch_rdata_g4", 64'(i_rdata), 64'hDEADBEEF);

    // Store then load of the same word.
    req_data(1'b1, 10'd7, 32'h12345678, g);
    @(negedge clk);
    chk("store_mem_we_g1", 64'(mem_we), 64'd1);
    chk("store_mem_wdata_g1", 64'(mem_wdata), 64'h12345678);
    wait_to(g + 4);
    chk("store_rvalid_g4", 64'(d_rvalid), 64'd1);
    chk("store_rdata_zero", 64'(d_rdata), 64'd0);
    req_data(1'b0, 10'd7, 32'h0, g);
    wait_to(g + 4);
    chk("load_rvalid_g4", 64'(d_rvalid), 64'd1);
    chk("load_rdata", 64'(d_rdata), 64'h12345678);

    // Sustained contention on both ports.
    step();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 10'd5; d_addr = 10'd7;
    ord = 64'd0; n = 0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge clk);
      if (i_gnt) begin ord = {ord[55:0], 8'h49}; n++; end
      if (d_gnt) begin ord = {ord[55:0], 8'h44}; n++; end
      step();
    end
    i_req = 1'b0; d_req = 1'b0; i_addr = 10'd0; d_addr = 10'd0;
    chk("arb_order", ord, EXP_ORD);

    // Flush two cycles after the grant: no pulse, immediate regrant at G+5.
    req_fetch(10'd9, g);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    wait_to(g + 4);
    chk("flush_no_rvalid", 64'(i_rvalid), 64'd0);
    chk("flush_busy_resp", 64'(busy), 64'd1);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5;
    @(negedge clk);
    chk("flush_regrant_g5", 64'(d_gnt), 64'd1);
    g2 = pc;
    step();
    d_req = 1'b0; d_addr = 10'd0;
    wait_to(g2 + 4);
    chk("load5_rdata", 64'(d_rdata), 64'hDEADBEEF);

    // Flush during RESP itself: pulse suppressed, held data unchanged.
    req_fetch(10'd3, g);
    wait_to(g + 3);
    step();
    i_flush = 1'b1;
    @(negedge clk);
    chk("resp_flush_no_rvalid", 64'(i_rvalid), 64'd0);
    chk("resp_flush_hold", 64'(i_rdata), 64'hDEADBEEF);
    step();
    i_flush = 1'b0;

    // Reset in the middle of a load.
    req_data(1'b0, 10'd5, 32'h0, g);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd7;
    @(negedge clk);
    chk("rst_busy_clear", 64'(busy), 64'd0);
    chk("rst_rdata_clear", 64'(d_rdata), 64'd0);
    chk("rst_regrant", 64'(d_gnt), 64'd1);
    g = pc;
    step();
    d_req = 1'b0; d_addr = 10'd0;
    wait_to(g + 4);
    chk("post_rst_load", 64'(d_rdata), 64'h12345678);
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
